// File: rtl/dbus_pkg.sv
// Shared definitions for the data-side bus controller: MMIO map, STATUS layout, UART FSM encoding.
package dbus_pkg;

    localparam logic [31:0] MMIO_BASE     = 32'h8000_0000;
    localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_BUSY    = 1;
    localparam int unsigned STAT_ERR     = 2;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Halfword stores need addr[0]=0, word stores need addr[1:0]=0.
    function automatic logic misaligned(input logic [3:0] we, input logic [1:0] ofs);
        return (we[1] && ofs[0]) || (we[3] && (ofs != 2'b00));
    endfunction

endpackage

// File: rtl/dbus_if.sv
// Core EM-stage memory port: core is master, bus controller is slave.
interface dbus_if;
    logic [31:0] mem_addr;
    logic        mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;

    modport master (output mem_addr, mem_oe, mem_wdata, mem_we,
                    input  mem_rdata, mem_valid, mem_ready);
    modport slave  (input  mem_addr, mem_oe, mem_wdata, mem_we,
                    output mem_rdata, mem_valid, mem_ready);
endinterface

// File: rtl/uart_tx_q.sv
// Circular TX FIFO feeding an 8N1 LSB-first serial shifter.
module uart_tx_q
    import dbus_pkg::*;
#(
    parameter int unsigned UART_DIV  = 868,
    parameter int unsigned TXQ_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [7:0]            pdata,
    output logic                  full,
    output logic [STAT_CNT_W-1:0] count,
    output logic                  busy,
    output logic                  tx
);

    localparam int unsigned PW = $clog2(TXQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;

    logic [7:0]    q [TXQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    tx_state_t     state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          tx_n;
    logic          pop;
    logic          bit_end;
    logic          do_push;

    assign full    = (cnt == CW'(TXQ_DEPTH));
    assign count   = STAT_CNT_W'(cnt);
    assign busy    = (state != TX_IDLE) || (cnt != '0);
    assign do_push = push && !full;
    assign bit_end = (state != TX_IDLE) && (div_cnt == DW'(UART_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_n;
    end

    // Next state; STOP chains straight into START when more data is queued.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            TX_IDLE:  if (cnt != '0) begin state_n = TX_START; pop = 1'b1; end
            TX_START: if (bit_end) state_n = TX_DATA;
            TX_DATA:  if (bit_end && (idx == 3'd7)) state_n = TX_STOP;
            TX_STOP:  if (bit_end) begin
                          if (cnt != '0) begin state_n = TX_START; pop = 1'b1; end
                          else                 state_n = TX_IDLE;
                      end
            default:  state_n = TX_IDLE;
        endcase
    end

    // Datapath next values; tx is registered so it changes together with state.
    always_comb begin
        div_n = ((state == TX_IDLE) || bit_end) ? '0 : div_cnt + DW'(1);
        idx_n = idx;
        if (state != TX_DATA) idx_n = '0;
        else if (bit_end)     idx_n = idx + 3'd1;
        sh_n  = pop ? q[rd_ptr] : sh;
        case (state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = sh_n[idx_n];
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            div_cnt <= div_n;
            idx     <= idx_n;
            sh      <= sh_n;
            tx      <= tx_n;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) q[wr_ptr] <= pdata;
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Data bus controller: RAM/MMIO decode, byte-lane alignment, load return, UART TX at MMIO.
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int unsigned RAM_AW    = 14,
    parameter int unsigned UART_DIV  = 868,
    parameter int unsigned TXQ_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dbus_if.slave             mem,
    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              uart_tx
);

    localparam logic [31:0] DATA_ADDR = MMIO_BASE + UART_DATA_OFS;
    localparam logic [31:0] STAT_ADDR = MMIO_BASE + UART_STAT_OFS;

    logic [1:0]            ofs;
    logic                  is_mmio, is_data, is_stat, is_store, misal;
    logic                  accept, st_ok, push;
    logic                  txq_full, tx_busy, err;
    logic [STAT_CNT_W-1:0] txq_count;
    logic [31:0]           stat_val, mmio_rd;
    logic                  valid_q, mmio_q;
    logic [1:0]            addr_q;
    logic [31:0]           mmio_rd_q, rdata_now, rdata_hold;

    assign ofs      = mem.mem_addr[1:0];
    assign is_mmio  = mem.mem_addr[31];
    assign is_data  = (mem.mem_addr[31:2] == DATA_ADDR[31:2]);
    assign is_stat  = (mem.mem_addr[31:2] == STAT_ADDR[31:2]);
    assign is_store = |mem.mem_we;
    assign misal    = is_store && misaligned(mem.mem_we, ofs);

    // Only a DATA push into a full FIFO stalls the core.
    assign mem.mem_ready = !(mem.mem_oe && is_store && is_data && txq_full);
    assign accept        = mem.mem_oe && mem.mem_ready;
    assign st_ok         = accept && is_store && !misal;
    assign push          = st_ok && is_data;

    assign ram_en    = accept && !is_mmio;
    assign ram_addr  = mem.mem_addr[RAM_AW+1:2];
    assign ram_we    = (st_ok && !is_mmio) ? 4'(mem.mem_we << ofs) : 4'b0000;
    assign ram_wdata = mem.mem_wdata << {ofs, 3'b000};

    always_comb begin
        stat_val                                = '0;
        stat_val[STAT_FULL]                     = txq_full;
        stat_val[STAT_BUSY]                     = tx_busy;
        stat_val[STAT_ERR]                      = err;
        stat_val[STAT_CNT_LSB +: STAT_CNT_W]    = txq_count;
        mmio_rd = is_stat ? stat_val : 32'h0;
    end

    // Sticky error: set by any misaligned store, cleared by writing 1 to STATUS bit 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        err <= 1'b0;
        else if (accept && misal)                          err <= 1'b1;
        else if (st_ok && is_stat && mem.mem_wdata[STAT_ERR]) err <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            mmio_q     <= 1'b0;
            addr_q     <= '0;
            mmio_rd_q  <= '0;
            rdata_hold <= '0;
        end else begin
            valid_q <= accept && !is_store;
            if (accept && !is_store) begin
                mmio_q    <= is_mmio;
                addr_q    <= ofs;
                mmio_rd_q <= mmio_rd;
            end
            if (valid_q) rdata_hold <= rdata_now;
        end
    end

    // RAM data arrives the cycle after ram_en, so the return path is a mux around the hold register.
    assign rdata_now     = (mmio_q ? mmio_rd_q : ram_rdata) >> {addr_q, 3'b000};
    assign mem.mem_rdata = valid_q ? rdata_now : rdata_hold;
    assign mem.mem_valid = valid_q;

    uart_tx_q #(
        .UART_DIV  (UART_DIV),
        .TXQ_DEPTH (TXQ_DEPTH)
    ) u_txq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pdata (mem.mem_wdata[7:0]),
        .full  (txq_full),
        .count (txq_count),
        .busy  (tx_busy),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: vector table for decode/alignment, sequences for UART and reset.
module tb_dbus_ctrl;

    localparam int unsigned RAM_AW    = 10;
    localparam int unsigned UART_DIV  = 4;
    localparam int unsigned TXQ_DEPTH = 16;
    localparam logic [31:0] DATA_A    = 32'h8000_0000;
    localparam logic [31:0] STAT_A    = 32'h8000_0004;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dbus_if bus ();
    logic              ram_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              uart_tx;

    dbus_ctrl #(.RAM_AW(RAM_AW), .UART_DIV(UART_DIV), .TXQ_DEPTH(TXQ_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem       (bus),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .uart_tx   (uart_tx)
    );

    // Synchronous byte-write RAM, read data one cycle after enable.
    logic [31:0] ram [2**RAM_AW];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Serial receiver sampling mid-bit on the falling clock edge.
    logic [7:0] rxq [$];
    logic       rx_on = 1'b0;
    initial begin
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (rx_on && uart_tx === 1'b0) begin
                repeat (UART_DIV / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (UART_DIV) @(negedge clk);
                    d[b] = uart_tx;
                end
                repeat (UART_DIV) @(negedge clk);
                rxq.push_back(d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic oe, input logic [3:0] we, input logic [31:0] d);
        bus.mem_addr  = a;
        bus.mem_oe    = oe;
        bus.mem_we    = we;
        bus.mem_wdata = d;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        int n = 0;
        drive(a, 1'b1, we, d);
        #1;
        while (!bus.mem_ready && n < 300) begin tick(); n++; end
        if (!bus.mem_ready) chk("store_ready_timeout", 32'(bus.mem_ready), 32'd1);
        tick();
        drive(32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d, output logic v);
        drive(a, 1'b1, 4'h0, 32'h0);
        tick();
        v = bus.mem_valid;
        d = bus.mem_rdata;
        drive(32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        oe;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic oe, input logic [3:0] we,
                                input logic [31:0] d, input logic en, input logic [3:0] ewe,
                                input logic [31:0] ewd, input logic v, input logic [31:0] rd);
        vec_t r;
        r.addr = a; r.oe = oe; r.we = we; r.wdata = d;
        r.exp_en = en; r.exp_we = ewe; r.exp_wd = ewd; r.exp_valid = v; r.exp_rdata = rd;
        return r;
    endfunction

    localparam int NV = 15;
    vec_t tbl [NV];

    initial begin
        logic [31:0] d;
        logic        v;
        logic [31:0] bytes_sent [$];
        int          n;
        logic        early_stall;

        for (int i = 0; i < 2**RAM_AW; i++) ram[i] = 32'h0;
        ram_rdata = 32'h0;

        //           addr            oe  we    wdata          en  ram_we ram_wdata      valid rdata
        tbl[0]  = mk(32'h0000_0013, 1, 4'h1, 32'h0000_00A5, 1, 4'h8, 32'hA500_0000, 0, 32'h0);
        tbl[1]  = mk(32'h0000_0013, 1, 4'h0, 32'h0,         1, 4'h0, 32'h0,         1, 32'h0000_00A5);
        tbl[2]  = mk(32'h0000_0020, 1, 4'hF, 32'h1234_5678, 1, 4'hF, 32'h1234_5678, 0, 32'h0000_00A5);
        tbl[3]  = mk(32'h0000_0022, 1, 4'h0, 32'h0,         1, 4'h0, 32'h0,         1, 32'h0000_1234);
        tbl[4]  = mk(32'h0000_0020, 1, 4'h0, 32'h0,         1, 4'h0, 32'h0,         1, 32'h1234_5678);
        tbl[5]  = mk(32'h0000_0000, 0, 4'h0, 32'h0,         0, 4'h0, 32'h0,         0, 32'h1234_5678);
        tbl[6]  = mk(32'h0000_0021, 1, 4'h3, 32'h0000_BEEF, 1, 4'h0, 32'h0,         0, 32'h1234_5678);
        tbl[7]  = mk(STAT_A,        1, 4'h0, 32'h0,         0, 4'h0, 32'h0,         1, 32'h0000_0004);
        tbl[8]  = mk(STAT_A,        1, 4'hF, 32'h0000_0004, 0, 4'h0, 32'h0,         0, 32'h0000_0004);
        tbl[9]  = mk(STAT_A,        1, 4'h0, 32'h0,         0, 4'h0, 32'h0,         1, 32'h0);
        tbl[10] = mk(32'h8000_0008, 1, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, 32'h0,         0, 32'h0);
        tbl[11] = mk(32'h8000_0008, 1, 4'h0, 32'h0,         0, 4'h0, 32'h0,         1, 32'h0);
        tbl[12] = mk(32'h0001_0013, 1, 4'h0, 32'h0,         1, 4'h0, 32'h0,         1, 32'h0000_00A5);
        tbl[13] = mk(32'h0000_0022, 1, 4'h0, 32'h0,         1, 4'h0, 32'h0,         1, 32'h0000_1234);
        tbl[14] = mk(DATA_A,        1, 4'h0, 32'h0,         0, 4'h0, 32'h0,         1, 32'h0);

        drive(32'h0, 1'b0, 4'h0, 32'h0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_valid",   32'(bus.mem_valid), 32'd0);
        chk("rst_rdata",   bus.mem_rdata, 32'h0);
        chk("rst_ready",   32'(bus.mem_ready), 32'd1);
        chk("rst_ram_en",  32'(ram_en), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].addr, tbl[i].oe, tbl[i].we, tbl[i].wdata);
            #1;
            chk($sformatf("row%0d ready", i), 32'(bus.mem_ready), 32'd1);
            chk($sformatf("row%0d ram_en", i), 32'(ram_en), 32'(tbl[i].exp_en));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we != 4'h0)
                chk($sformatf("row%0d ram_wdata", i), ram_wdata, tbl[i].exp_wd);
            tick();
            chk($sformatf("row%0d valid", i), 32'(bus.mem_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("row%0d rdata", i), bus.mem_rdata, tbl[i].exp_rdata);
        end
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        tick();

        // Single frame of 0x55: start, LSB-first data, stop, each UART_DIV cycles.
        store(DATA_A, 4'h1, 32'h0000_0055);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin tick(); n++; end
        begin
            logic [9:0] frame;
            frame = {1'b1, 8'h55, 1'b0};
            for (int k = 0; k < 10; k++)
                for (int j = 0; j < int'(UART_DIV); j++) begin
                    chk($sformatf("frame bit%0d cyc%0d", k, j), 32'(uart_tx), 32'(frame[k]));
                    tick();
                end
        end
        load(STAT_A, d, v);
        chk("idle_status_valid", 32'(v), 32'd1);
        chk("idle_status", d, 32'h0);

        // Fill the FIFO; the first byte is popped straight away, so DEPTH+1 pushes fill it.
        rx_on = 1'b1;
        early_stall = 1'b0;
        for (int i = 0; i < int'(TXQ_DEPTH) + 1; i++) begin
            drive(DATA_A, 1'b1, 4'h1, 32'(8'h10 + 8'(i)));
            #1;
            if (!bus.mem_ready) early_stall = 1'b1;
            bytes_sent.push_back(32'(8'h10 + 8'(i)));
            tick();
        end
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        chk("fill_no_early_stall", 32'(early_stall), 32'd0);
        load(STAT_A, d, v);
        chk("full_status", d, (32'(TXQ_DEPTH) << 8) | 32'h3);

        drive(DATA_A, 1'b1, 4'h1, 32'(8'h10 + 8'(TXQ_DEPTH + 1)));
        #1;
        chk("full_ready_low", 32'(bus.mem_ready), 32'd0);
        n = 0;
        while (!bus.mem_ready && n < 200) begin tick(); n++; end
        chk("ready_after_pop", 32'(bus.mem_ready), 32'd1);
        chk("stalled_until_pop", 32'(n >= int'(UART_DIV) * 5), 32'd1);
        bytes_sent.push_back(32'(8'h10 + 8'(TXQ_DEPTH + 1)));
        tick();
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        load(STAT_A, d, v);
        chk("refill_status", d, (32'(TXQ_DEPTH) << 8) | 32'h3);

        n = 0;
        while (rxq.size() < bytes_sent.size() && n < (int'(TXQ_DEPTH) + 4) * int'(UART_DIV) * 12) begin
            tick(); n++;
        end
        chk("rx_count", 32'(rxq.size()), 32'(bytes_sent.size()));
        for (int i = 0; i < rxq.size() && i < bytes_sent.size(); i++)
            chk($sformatf("rx_byte%0d", i), 32'(rxq[i]), bytes_sent[i]);
        repeat (3 * UART_DIV) tick();
        rx_on = 1'b0;

        // Misaligned MMIO store sets err; reset mid-frame clears everything at once.
        store(32'h8000_0006, 4'hF, 32'h0);
        store(DATA_A, 4'h1, 32'h0);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin tick(); n++; end
        chk("c_frame_start", 32'(uart_tx), 32'd0);
        load(STAT_A, d, v);
        chk("c_status_err_busy", d, 32'h0000_0006);
        drive(32'h0000_0020, 1'b1, 4'h0, 32'h0);
        tick();
        chk("c_pre_valid", 32'(bus.mem_valid), 32'd1);
        chk("c_pre_rdata", bus.mem_rdata, 32'h1234_5678);
        chk("c_pre_tx", 32'(uart_tx), 32'd0);
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("c_rst_tx", 32'(uart_tx), 32'd1);
        chk("c_rst_valid", 32'(bus.mem_valid), 32'd0);
        chk("c_rst_rdata", bus.mem_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("c_post_tx", 32'(uart_tx), 32'd1);
        load(STAT_A, d, v);
        chk("c_post_status", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
